// File: rtl/booth_div_pkg.sv
// booth_div_pkg: shared FSM state type and sizing helper for the signed restoring divider
package booth_div_pkg;
  typedef enum logic [2:0] {IDLE, CHECK, RUN, FIX, DONE} state_t;
  function automatic int cnt_w(input int n);
    return $clog2(n + 1);
  endfunction
endpackage

// File: rtl/booth_divider_div_step.sv
// div_step: one combinational restoring-division step (shift in next dividend bit, trial subtract)
module div_step #(
  parameter int N = 4
) (
  input  logic [N-1:0] r_i,
  input  logic         qmsb_i,
  input  logic [N-1:0] magv_i,
  output logic [N-1:0] r_o,
  output logic         qbit_o
);
  logic [N:0] sh, t;
  // keep the difference when the trial subtraction does not borrow, otherwise restore
  always_comb begin
    sh = {r_i, qmsb_i};
    t = sh - {1'b0, magv_i};
    qbit_o = ~t[N];
    r_o = t[N] ? sh[N-1:0] : t[N-1:0];
  end
endmodule

// File: rtl/booth_divider.sv
// booth_divider: sequential signed restoring divider, 2N-bit dividend by N-bit divisor
module booth_divider
  import booth_div_pkg::*;
#(
  parameter int N = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [2*N-1:0] data_D,
  input  logic [N-1:0]   data_V,
  output logic           busy,
  output logic           done,
  output logic [N-1:0]   quot,
  output logic [N-1:0]   rem,
  output logic           dz,
  output logic           ovf
);
  localparam int CW = cnt_w(N);
  localparam logic [N-1:0] HALF = {1'b1, {(N-1){1'b0}}};
  localparam logic [N-1:0] MAXP = {1'b0, {(N-1){1'b1}}};
  state_t state_q, state_d;
  logic [2*N-1:0] d_q, d_d, mag_d;
  logic [N-1:0] v_q, v_d, mag_v, r_q, r_d, qr_q, qr_d, quot_q, quot_d, rem_q, rem_d, step_r;
  logic [CW-1:0] cnt_q, cnt_d;
  logic sd_q, sd_d, sv_q, sv_d, dz_q, dz_d, ovf_q, ovf_d, step_q, qneg;
  assign mag_d = d_q[2*N-1] ? -d_q : d_q;
  assign mag_v = v_q[N-1] ? -v_q : v_q;
  assign qneg = sd_q ^ sv_q;
  div_step #(.N(N)) u_step (
    .r_i(r_q),
    .qmsb_i(qr_q[N-1]),
    .magv_i(mag_v),
    .r_o(step_r),
    .qbit_o(step_q)
  );
  // controller next state plus datapath next values, everything holds by default
  always_comb begin
    state_d = state_q;
    d_d = d_q;
    v_d = v_q;
    sd_d = sd_q;
    sv_d = sv_q;
    r_d = r_q;
    qr_d = qr_q;
    cnt_d = cnt_q;
    quot_d = quot_q;
    rem_d = rem_q;
    dz_d = dz_q;
    ovf_d = ovf_q;
    case (state_q)
      IDLE: if (start) begin
        d_d = data_D;
        v_d = data_V;
        sd_d = data_D[2*N-1];
        sv_d = data_V[N-1];
        dz_d = 1'b0;
        ovf_d = 1'b0;
        state_d = CHECK;
      end
      CHECK: begin
        if (v_q == '0) begin
          dz_d = 1'b1;
          quot_d = '0;
          rem_d = '0;
          state_d = DONE;
        end else if (mag_d[2*N-1:N] >= mag_v) begin
          ovf_d = 1'b1;
          quot_d = '0;
          rem_d = '0;
          state_d = DONE;
        end else begin
          r_d = mag_d[2*N-1:N];
          qr_d = mag_d[N-1:0];
          cnt_d = CW'(N);
          state_d = RUN;
        end
      end
      RUN: begin
        r_d = step_r;
        qr_d = {qr_q[N-2:0], step_q};
        cnt_d = cnt_q - CW'(1);
        state_d = (cnt_q == CW'(1)) ? FIX : RUN;
      end
      FIX: begin
        if (qneg ? (qr_q > HALF) : (qr_q > MAXP)) begin
          ovf_d = 1'b1;
          quot_d = '0;
          rem_d = '0;
        end else begin
          quot_d = qneg ? -qr_q : qr_q;
          rem_d = sd_q ? -r_q : r_q;
        end
        state_d = DONE;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  // state and datapath registers, cleared asynchronously so no partial result survives reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      d_q <= '0;
      v_q <= '0;
      sd_q <= 1'b0;
      sv_q <= 1'b0;
      r_q <= '0;
      qr_q <= '0;
      cnt_q <= '0;
      quot_q <= '0;
      rem_q <= '0;
      dz_q <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      state_q <= state_d;
      d_q <= d_d;
      v_q <= v_d;
      sd_q <= sd_d;
      sv_q <= sv_d;
      r_q <= r_d;
      qr_q <= qr_d;
      cnt_q <= cnt_d;
      quot_q <= quot_d;
      rem_q <= rem_d;
      dz_q <= dz_d;
      ovf_q <= ovf_d;
    end
  end
  assign busy = (state_q == CHECK) || (state_q == RUN) || (state_q == FIX);
  assign done = (state_q == DONE);
  assign quot = quot_q;
  assign rem = rem_q;
  assign dz = dz_q;
  assign ovf = ovf_q;
endmodule

// File: tb/tb_booth_divider.sv
// tb_booth_divider: directed self-checking bench for booth_divider with N=4
module tb_booth_divider;
  localparam int N = 4;
  typedef struct {
    logic [7:0] d;
    logic [3:0] v;
    logic [9:0] exp;
    int lat;
  } vec_t;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic [2*N-1:0] data_D = '0;
  logic [N-1:0] data_V = '0, quot, rem;
  logic busy, done, dz, ovf;
  int tests = 0, fails = 0;

  booth_divider #(.N(N)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .data_D(data_D), .data_V(data_V),
    .busy(busy), .done(done), .quot(quot), .rem(rem), .dz(dz), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic run_op(input logic [7:0] d, input logic [3:0] v, output int edges, output bit busy_ok);
    @(negedge clk);
    data_D = d;
    data_V = v;
    start = 1'b1;
    @(posedge clk);
    edges = 1;
    busy_ok = 1'b1;
    @(negedge clk);
    start = 1'b0;
    while (!done && edges < 30) begin
      if (!busy) busy_ok = 1'b0;
      @(posedge clk);
      edges++;
      @(negedge clk);
    end
    if (busy) busy_ok = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    tests++;
    if ({busy, done, dz, ovf, quot, rem} !== 12'h0) begin
      fails++;
      $display("FAIL reset_state: got %h want 000", {busy, done, dz, ovf, quot, rem});
    end
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    int e;
    bit b;
    run_op(8'h23, 4'h5, e, b);
    tests++;
    if ({quot, rem, dz, ovf} !== {4'h7, 4'h0, 2'b00}) begin
      fails++;
      $display("FAIL basic_result: got %h want %h", {quot, rem, dz, ovf}, {4'h7, 4'h0, 2'b00});
    end
    tests++;
    if (e !== 7) begin
      fails++;
      $display("FAIL basic_latency: got %0d want 7", e);
    end
    tests++;
    if (b !== 1'b1) begin
      fails++;
      $display("FAIL basic_busy: busy not high throughout or high with done");
    end
  endtask

  task automatic test_vectors(input string name, input vec_t tbl[3], input int cnt);
    int e;
    bit b;
    for (int i = 0; i < cnt; i++) begin
      run_op(tbl[i].d, tbl[i].v, e, b);
      tests++;
      if ({quot, rem, dz, ovf} !== tbl[i].exp) begin
        fails++;
        $display("FAIL %s_%0d_result: D=%h V=%h got %h want %h", name, i, tbl[i].d, tbl[i].v, {quot, rem, dz, ovf}, tbl[i].exp);
      end
      tests++;
      if (e !== tbl[i].lat) begin
        fails++;
        $display("FAIL %s_%0d_latency: got %0d want %0d", name, i, e, tbl[i].lat);
      end
    end
  endtask

  task automatic test_signs();
    vec_t t[3];
    t[0] = '{8'hEC, 4'h3, {4'hA, 4'hE, 2'b00}, 7};
    t[1] = '{8'h14, 4'hD, {4'hA, 4'h2, 2'b00}, 7};
    t[2] = '{8'h00, 4'h0, 10'h0, 0};
    test_vectors("signs", t, 2);
  endtask

  task automatic test_limits();
    vec_t t[3];
    t[0] = '{8'hE0, 4'h4, {4'h8, 4'h0, 2'b00}, 7};
    t[1] = '{8'h20, 4'h4, {4'h0, 4'h0, 2'b01}, 7};
    t[2] = '{8'h50, 4'h3, {4'h0, 4'h0, 2'b01}, 2};
    test_vectors("limits", t, 3);
  endtask

  task automatic test_div_zero();
    vec_t t[3];
    t[0] = '{8'h11, 4'h0, {4'h0, 4'h0, 2'b10}, 2};
    t[1] = '{8'h07, 4'h2, {4'h3, 4'h1, 2'b00}, 7};
    t[2] = '{8'h00, 4'h0, 10'h0, 0};
    test_vectors("divzero", t, 2);
  endtask

  task automatic test_held_start();
    int cyc, extra;
    @(negedge clk);
    data_D = 8'h23;
    data_V = 4'h5;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    data_D = 8'h07;
    data_V = 4'h2;
    cyc = 1;
    while (!done && cyc < 30) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
    end
    tests++;
    if ({quot, rem, cyc[7:0]} !== {4'h7, 4'h0, 8'd7}) begin
      fails++;
      $display("FAIL held_first: quot/rem/edges got %h/%h/%0d want 7/0/7", quot, rem, cyc);
    end
    @(posedge clk);
    cyc = 1;
    @(negedge clk);
    while (!done && cyc < 30) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
    end
    tests++;
    if ({quot, rem, cyc[7:0]} !== {4'h3, 4'h1, 8'd8}) begin
      fails++;
      $display("FAIL held_second: quot/rem/period got %h/%h/%0d want 3/1/8", quot, rem, cyc);
    end
    start = 1'b0;
    extra = 0;
    repeat (12) begin
      @(posedge clk);
      @(negedge clk);
      if (done || busy) extra++;
    end
    tests++;
    if (extra !== 0) begin
      fails++;
      $display("FAIL held_stop: got %0d busy/done cycles after release want 0", extra);
    end
  endtask

  task automatic test_reset_mid();
    int e;
    bit b;
    @(negedge clk);
    data_D = 8'h23;
    data_V = 4'h5;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    tests++;
    if (busy !== 1'b1) begin
      fails++;
      $display("FAIL mid_busy: got %b want 1", busy);
    end
    rst_n = 1'b0;
    #1;
    tests++;
    if ({busy, done, dz, ovf, quot, rem} !== 12'h0) begin
      fails++;
      $display("FAIL mid_reset: got %h want 000", {busy, done, dz, ovf, quot, rem});
    end
    @(negedge clk);
    rst_n = 1'b1;
    run_op(8'h09, 4'h2, e, b);
    tests++;
    if ({quot, rem, dz, ovf} !== {4'h4, 4'h1, 2'b00}) begin
      fails++;
      $display("FAIL post_reset_result: got %h want %h", {quot, rem, dz, ovf}, {4'h4, 4'h1, 2'b00});
    end
    tests++;
    if (e !== 7) begin
      fails++;
      $display("FAIL post_reset_latency: got %0d want 7", e);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_signs();
    test_limits();
    test_div_zero();
    test_held_start();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/booth_divider.md
Name: booth_divider

Overview:
- Sequential signed restoring divider. It is the inverse companion of the N-bit Booth multiplier.
- It takes a 2N-bit two's-complement dividend (the same width as the multiplier product) and an N-bit two's-complement divisor.
- It returns an N-bit quotient truncated toward zero and an N-bit remainder.
- Sits beside the multiplier in the arithmetic unit and uses the same start/done style of controller with a separate datapath.

Parameters:
N, 4, operand width; dividend is 2N bits, divisor/quotient/remainder are N bits; N >= 2.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
start  input  1  request; sampled only in IDLE
data_D  input  2N  dividend, signed; captured on the accepted start edge
data_V  input  N  divisor, signed; captured on the accepted start edge
busy  output  1  high from the cycle after an accepted start until done
done  output  1  one-cycle pulse; results are valid when it is high
quot  output  N  quotient, signed; held until the next accepted start
rem  output  N  remainder, signed, carries the sign of the dividend; held
dz  output  1  divide-by-zero flag; valid with done
ovf  output  1  quotient does not fit in N signed bits; valid with done

Behaviour:
Reset:
- rst_n low, at any time including mid-operation: state goes to IDLE.
- busy, done, dz, ovf, quot and rem all go to 0. The iteration counter goes to 0.
- There is no partial-result leakage.

States: IDLE -> CHECK -> RUN -> FIX -> DONE -> IDLE.
- IDLE: when start=1, latch data_D/data_V, signD = D[2N-1], signV = V[N-1]; go to CHECK. start is ignored in every other state.
- CHECK: form magD = |D| (2N-bit unsigned) and magV = |V| (N-bit unsigned). -2^(2N-1) and -2^(N-1) map to 2^(2N-1) and 2^(N-1).
  - If V == 0: set dz=1, quot=0, rem=0; go to DONE.
  - Else if magD[2N-1:N] >= magV (unsigned overflow): set ovf=1, quot=0, rem=0; go to DONE.
  - Else: load R (N+1 bits) = {0, magD[2N-1:N]}, Qr = magD[N-1:0], counter = N; go to RUN.
- RUN, one restoring step per cycle:
  - T = {R[N-1:0], Qr[N-1]} - {0, magV}.
  - If T is non-negative: R = T, Qr = {Qr[N-2:0], 1}.
  - Else: R = {R[N-1:0], Qr[N-1]}, Qr = {Qr[N-2:0], 0}.
  - Decrement counter. When counter reaches 0 (eqz), go to FIX.
- FIX:
  - qneg = signD XOR signV.
  - If qneg and Qr > 2^(N-1), or !qneg and Qr > 2^(N-1)-1: set ovf=1, quot=0, rem=0.
  - Else: quot = qneg ? -Qr : Qr; rem = signD ? -R[N-1:0] : R[N-1:0].
  - Go to DONE.
- DONE: done=1 for exactly this cycle, busy=0; return to IDLE. A start presented during DONE is ignored.

Timing and flags:
- Latency, normal path: done is high in the cycle after the (N+3)th rising edge following the start-sampling edge (N+3 edges; 7 for N=4).
- Latency, dz/ovf early exit from CHECK: 2 edges.
- dz and ovf are mutually exclusive. Both clear on the next accepted start.
- Invariant when no flag is set: D == quot*V + rem, |rem| < |V|, and rem is 0 or has the sign of D.

Decomposition:
- Package booth_div_pkg holds:
  - state typedef {IDLE, CHECK, RUN, FIX, DONE}
  - counter width function clog2(N+1)
- Natural sub-module div_step: combinational single restoring step.
  - Inputs: R, Qr_msb, magV.
  - Outputs: next R, quotient bit.
- The controller FSM and counter stay in the top module.

Test Plan:
- N=4, D=8'h23 (35), V=4'h5, start pulse -> done 7 edges later; quot=4'h7, rem=4'h0, dz=0, ovf=0; busy high throughout.
- D=8'hEC (-20), V=4'h3 -> quot=4'hA (-6), rem=4'hE (-2); D=8'h14 (20), V=4'hD (-3) -> quot=4'hA, rem=4'h2.
- Negative-limit boundary:
  - D=8'hE0 (-32), V=4'h4 -> quot=4'h8 (-8), rem=0, ovf=0.
  - D=8'h20 (32), V=4'h4 -> ovf=1 via FIX, quot=0.
  - D=8'h50, V=4'h3 -> ovf=1 via CHECK, done after 2 edges.
- D=8'h11, V=4'h0 -> dz=1, ovf=0, quot=0, rem=0, done after 2 edges; a second start with D=8'h07, V=4'h2 clears dz and returns quot=3, rem=1.
- start held high continuously -> a new operation begins only in IDLE; operations do not overlap; exactly one done pulse per operation.
- Assert rst_n low during RUN (3rd iteration) -> all outputs are 0 immediately (asynchronously); after release, a fresh D=8'h09, V=4'h2 gives quot=4, rem=1 with normal latency.
